arduino_link_sched: RTL and testbench

- Schedules ball-detection results from up to N_BALLS image-processing requesters onto the 10-bit parallel Arduino link: ball[2:0], ctrl[1:0] and val[4:0], all outputs.
- Each payload is 10 bits, e.g. an x coordinate 0..639. It is sent as two timed 5-bit symbols, then an idle gap.
- Requesters share the link round-robin. End of frame is signalled once per frame, after all pending data has been drained.
- Sits between the eee_imgproc detection outputs and the Arduino PIO pins.

---
 rtl/arduino_link_pkg.sv | 22 ++
 rtl/arduino_link_sched_rr_arbiter.sv | 33 +++
 rtl/arduino_link_sched.sv | 167 ++++++++++++++++
 tb/tb_arduino_link_sched.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/arduino_link_pkg.sv
// rtl/arduino_link_pkg.sv - shared encodings, widths and FSM states for the Arduino link scheduler
package arduino_link_pkg;

    localparam logic [1:0] CTRL_IDLE = 2'b00;
    localparam logic [1:0] CTRL_HI   = 2'b01;
    localparam logic [1:0] CTRL_LO   = 2'b10;
    localparam logic [1:0] CTRL_EOF  = 2'b11;

    localparam logic [2:0] EOF_ID    = 3'd7;

    localparam int PAYLOAD_W = 10;
    localparam int SYM_W     = 5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HI,
        ST_LO,
        ST_GAP,
        ST_EOF
    } state_t;

endpackage

// File: rtl/arduino_link_sched_rr_arbiter.sv
// rtl/arduino_link_sched_rr_arbiter.sv - combinational round-robin arbiter, first request at or after ptr
module rr_arbiter #(
    parameter int N = 6
) (
    input  logic [N-1:0] req,
    input  logic [2:0]   ptr,
    output logic [N-1:0] grant,
    output logic [2:0]   grant_idx,
    output logic         grant_valid
);

    // Two passes: indices from ptr upward, then the wrapped indices below ptr.
    always_comb begin
        grant       = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        for (int j = 0; j < N; j++) begin
            if (!grant_valid && j >= int'(ptr) && req[j]) begin
                grant_valid = 1'b1;
                grant[j]    = 1'b1;
                grant_idx   = 3'(j);
            end
        end
        for (int j = 0; j < N; j++) begin
            if (!grant_valid && j < int'(ptr) && req[j]) begin
                grant_valid = 1'b1;
                grant[j]    = 1'b1;
                grant_idx   = 3'(j);
            end
        end
    end

endmodule

// File: rtl/arduino_link_sched.sv
// rtl/arduino_link_sched.sv - schedules ball payloads and end-of-frame onto the 10-bit Arduino link
module arduino_link_sched
    import arduino_link_pkg::*;
#(
    parameter int N_BALLS     = 6,
    parameter int HOLD_CYCLES = 64,
    parameter int GAP_CYCLES  = 32
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [N_BALLS-1:0]             req_valid,
    input  logic [N_BALLS*PAYLOAD_W-1:0]   req_data,
    input  logic                           frame_done,
    output logic [2:0]                     ball_out,
    output logic [1:0]                     ctrl_out,
    output logic [SYM_W-1:0]               val_out,
    output logic                           busy,
    output logic [15:0]                    drop_count
);

    localparam int MAX_CYC = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC) + 1;
    localparam logic [CNT_W-1:0] HOLD_LD = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LD  = CNT_W'(GAP_CYCLES - 1);
    localparam logic [2:0]       LAST_ID = 3'(N_BALLS - 1);

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [N_BALLS-1:0]   pending_q;
    logic [PAYLOAD_W-1:0] data_q [N_BALLS];
    logic                 eof_q;
    logic [2:0]           ptr_q;
    logic [SYM_W-1:0]     lo_sym_q;
    logic [2:0]           ball_q, ball_d;
    logic [1:0]           ctrl_q, ctrl_d;
    logic [SYM_W-1:0]     val_q, val_d;
    logic                 busy_q;
    logic [15:0]          drop_q, drop_next;

    logic [N_BALLS-1:0]   grant_oh, clr_mask, drops;
    logic [2:0]           grant_idx;
    logic                 grant_any, take_grant, take_eof;
    logic [PAYLOAD_W-1:0] grant_data;
    logic [3:0]           n_drop;
    logic [16:0]          drop_sum;

    rr_arbiter #(.N(N_BALLS)) u_arb (
        .req         (pending_q),
        .ptr         (ptr_q),
        .grant       (grant_oh),
        .grant_idx   (grant_idx),
        .grant_valid (grant_any)
    );

    always_comb begin
        grant_data = '0;
        for (int i = 0; i < N_BALLS; i++) begin
            if (grant_oh[i]) grant_data = grant_data | data_q[i];
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q - 1'b1;
        ball_d     = ball_q;
        ctrl_d     = ctrl_q;
        val_d      = val_q;
        take_grant = 1'b0;
        take_eof   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cnt_d = cnt_q;
                if (grant_any) begin
                    take_grant = 1'b1;
                    state_d    = ST_HI;
                    cnt_d      = HOLD_LD;
                    ball_d     = grant_idx;
                    ctrl_d     = CTRL_HI;
                    val_d      = grant_data[PAYLOAD_W-1:SYM_W];
                end else if (eof_q) begin
                    take_eof = 1'b1;
                    state_d  = ST_EOF;
                    cnt_d    = HOLD_LD;
                    ball_d   = EOF_ID;
                    ctrl_d   = CTRL_EOF;
                    val_d    = '0;
                end
            end
            ST_HI: begin
                if (cnt_q == '0) begin
                    state_d = ST_LO;
                    cnt_d   = HOLD_LD;
                    ctrl_d  = CTRL_LO;
                    val_d   = lo_sym_q;
                end
            end
            ST_LO, ST_EOF: begin
                if (cnt_q == '0) begin
                    state_d = ST_GAP;
                    cnt_d   = GAP_LD;
                    ball_d  = '0;
                    ctrl_d  = CTRL_IDLE;
                    val_d   = '0;
                end
            end
            ST_GAP: begin
                if (cnt_q == '0) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // A request landing on its own grant cycle re-arms pending without counting a drop.
    always_comb begin
        clr_mask = take_grant ? grant_oh : '0;
        drops    = req_valid & pending_q & ~clr_mask;
        n_drop   = '0;
        for (int i = 0; i < N_BALLS; i++) begin
            n_drop = n_drop + 4'(drops[i]);
        end
        drop_sum  = {1'b0, drop_q} + 17'(n_drop);
        drop_next = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            pending_q <= '0;
            eof_q     <= 1'b0;
            ptr_q     <= '0;
            lo_sym_q  <= '0;
            ball_q    <= '0;
            ctrl_q    <= CTRL_IDLE;
            val_q     <= '0;
            busy_q    <= 1'b0;
            drop_q    <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pending_q <= (pending_q & ~clr_mask) | req_valid;
            eof_q     <= (eof_q & ~take_eof) | frame_done;
            ball_q    <= ball_d;
            ctrl_q    <= ctrl_d;
            val_q     <= val_d;
            busy_q    <= (state_d != ST_IDLE);
            drop_q    <= drop_next;
            if (take_grant) begin
                lo_sym_q <= grant_data[SYM_W-1:0];
                ptr_q    <= (grant_idx == LAST_ID) ? 3'd0 : grant_idx + 3'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < N_BALLS; i++) begin
            if (req_valid[i]) data_q[i] <= req_data[i*PAYLOAD_W +: PAYLOAD_W];
        end
    end

    assign ball_out   = ball_q;
    assign ctrl_out   = ctrl_q;
    assign val_out    = val_q;
    assign busy       = busy_q;
    assign drop_count = drop_q;

endmodule

// File: tb/tb_arduino_link_sched.sv
// tb/tb_arduino_link_sched.sv - directed self-checking bench for arduino_link_sched (HOLD=4, GAP=2)
module tb_arduino_link_sched;

    localparam int N    = 6;
    localparam int HOLD = 4;
    localparam int GAP  = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic [5:0]  req_valid;
    logic [59:0] req_data;
    logic        frame_done;
    logic [2:0]  ball_out;
    logic [1:0]  ctrl_out;
    logic [4:0]  val_out;
    logic        busy;
    logic [15:0] drop_count;

    int n_tests = 0;
    int n_fail  = 0;

    arduino_link_sched #(.N_BALLS(N), .HOLD_CYCLES(HOLD), .GAP_CYCLES(GAP)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .frame_done (frame_done),
        .ball_out   (ball_out),
        .ctrl_out   (ctrl_out),
        .val_out    (val_out),
        .busy       (busy),
        .drop_count (drop_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         id;
        logic [9:0] payload;
        logic [4:0] hi;
        logic [4:0] lo;
    } xfer_t;

    xfer_t tbl [5];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic pulse(input logic [5:0] mask, input logic [9:0] payload, input logic fd);
        for (int i = 0; i < N; i++) begin
            if (mask[i]) req_data[i*10 +: 10] = payload;
        end
        req_valid  = mask;
        frame_done = fd;
        step();
        req_valid  = '0;
        frame_done = 1'b0;
    endtask

    task automatic expect_sym(input string name, input logic [2:0] b, input logic [1:0] c,
                              input logic [4:0] v, input logic bs, input int n);
        for (int i = 0; i < n; i++) begin
            chk(name, {ball_out, ctrl_out, val_out, busy}, {b, c, v, bs});
            step();
        end
    endtask

    task automatic wait_ctrl(input logic [1:0] c, input int limit, output bit found);
        logic [1:0] prev;
        found = 1'b0;
        prev  = ctrl_out;
        for (int i = 0; i < limit && !found; i++) begin
            step();
            if (ctrl_out == c && prev != c) found = 1'b1;
            prev = ctrl_out;
        end
    endtask

    task automatic count_run(input logic [1:0] c, input logic b, output int n);
        n = 0;
        while (ctrl_out == c && busy == b && n < 100) begin
            n++;
            step();
        end
    endtask

    task automatic run_xfer(input int id, input logic [9:0] payload, input logic [4:0] hi, input logic [4:0] lo);
        pulse(6'(1 << id), payload, 1'b0);
        chk("lat_still_idle", {ctrl_out, busy}, 3'b000);
        step();
        expect_sym("xfer_hi",  3'(id), 2'b01, hi, 1'b1, HOLD);
        expect_sym("xfer_lo",  3'(id), 2'b10, lo, 1'b1, HOLD);
        expect_sym("xfer_gap", 3'd0, 2'b00, 5'd0, 1'b1, GAP);
        chk("xfer_idle", {ball_out, ctrl_out, val_out, busy}, 11'd0);
    endtask

    initial begin
        bit found;
        int n;

        tbl[0] = '{2, 10'h2A5, 5'h15, 5'h05};
        tbl[1] = '{0, 10'h3FF, 5'h1F, 5'h1F};
        tbl[2] = '{5, 10'h000, 5'h00, 5'h00};
        tbl[3] = '{3, 10'h1E0, 5'h0F, 5'h00};
        tbl[4] = '{1, 10'h27F, 5'h13, 5'h1F};

        reset = 1'b1; req_valid = '0; req_data = '0; frame_done = 1'b0;
        step(); step();
        chk("reset_outputs", {ball_out, ctrl_out, val_out, busy, drop_count}, 27'd0);
        reset = 1'b0;
        step();

        for (int t = 0; t < 5; t++) run_xfer(tbl[t].id, tbl[t].payload, tbl[t].hi, tbl[t].lo);
        chk("table_no_drops", drop_count, 16'd0);

        // round robin: 0,3,5 together, then 0 and 5 with pointer back at 0
        reset = 1'b1; step(); reset = 1'b0;
        pulse(6'b101001, 10'h3E0, 1'b0);
        wait_ctrl(2'b01, 40, found); chk("rr_found0", found, 1); chk("rr_ball0", {ball_out, val_out}, {3'd0, 5'h1F});
        wait_ctrl(2'b01, 40, found); chk("rr_found1", found, 1); chk("rr_ball1", ball_out, 3'd3);
        wait_ctrl(2'b01, 40, found); chk("rr_found2", found, 1); chk("rr_ball2", ball_out, 3'd5);
        pulse(6'b100001, 10'h3E0, 1'b0);
        wait_ctrl(2'b01, 40, found); chk("rr_found3", found, 1); chk("rr_ball3", ball_out, 3'd0);
        wait_ctrl(2'b01, 40, found); chk("rr_found4", found, 1); chk("rr_ball4", ball_out, 3'd5);

        // overwrite while busy: latest payload wins, one drop
        reset = 1'b1; step(); reset = 1'b0;
        pulse(6'b000001, 10'h2A5, 1'b0);
        pulse(6'b000010, 10'h001, 1'b0);
        pulse(6'b000010, 10'h3FF, 1'b0);
        chk("drop_one", drop_count, 16'd1);
        wait_ctrl(2'b01, 40, found); chk("ow_hi_found", found, 1); chk("ow_hi", {ball_out, val_out}, {3'd1, 5'h1F});
        wait_ctrl(2'b10, 40, found); chk("ow_lo_found", found, 1); chk("ow_lo", {ball_out, val_out}, {3'd1, 5'h1F});
        wait_ctrl(2'b01, 40, found); chk("ow_single_xfer", found, 0);

        // EOF after data drains; repeated frame_done gives one EOF
        reset = 1'b1; step(); reset = 1'b0;
        pulse(6'b000001, 10'h155, 1'b0);
        pulse(6'b010000, 10'h0AA, 1'b0);
        pulse(6'b000000, 10'h000, 1'b1);
        pulse(6'b000000, 10'h000, 1'b1);
        wait_ctrl(2'b01, 40, found); chk("eof_data_first", found, 1); chk("eof_data_ball", {ball_out, val_out}, {3'd4, 5'h05});
        wait_ctrl(2'b11, 40, found); chk("eof_found", found, 1);
        chk("eof_sym", {ball_out, val_out, busy}, {3'd7, 5'd0, 1'b1});
        count_run(2'b11, 1'b1, n); chk("eof_hold", n, HOLD);
        count_run(2'b00, 1'b1, n); chk("eof_gap", n, GAP);
        chk("eof_idle", {ctrl_out, busy}, 3'b000);
        wait_ctrl(2'b11, 60, found); chk("eof_only_once", found, 0);

        // reset mid-LO abandons the transfer and the pending request
        pulse(6'b000100, 10'h2A5, 1'b0);
        pulse(6'b001000, 10'h111, 1'b0);
        pulse(6'b001000, 10'h222, 1'b0);
        wait_ctrl(2'b10, 40, found); chk("rst_lo_found", found, 1);
        chk("rst_pre_drop", drop_count, 16'd1);
        step();
        reset = 1'b1; step(); reset = 1'b0;
        chk("rst_mid_lo", {ball_out, ctrl_out, val_out, busy, drop_count}, 27'd0);
        wait_ctrl(2'b01, 40, found); chk("rst_pending_gone", found, 0);

        // saturation: one channel requesting every cycle
        req_data[19:10] = 10'h123;
        req_valid = 6'b000010;
        for (int i = 0; i < 76000; i++) step();
        req_valid = '0;
        chk("drop_saturate", drop_count, 16'hFFFF);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
